pixel_reorder_arbiter: RTL and testbench
========================================

Name: pixel_reorder_arbiter

Overview:
- Collects out-of-order pixel results from NUM_QUEUES per-engine reorder queues and emits them as a strict raster-order stream.
- Broadcasts the next expected coordinate (x_check, y_check) to all queues and pops whichever queue head matches.
- Drives a valid/ready pixel stream toward the video output stage, with start-of-frame, end-of-line, frame-done and error reporting.

Parameters:
- NUM_QUEUES, 4, number of engine queues arbitrated
- DATA_WIDTH, 10, coordinate width
- RGB_SIZE, 24, colour width
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- TIMEOUT, 1023, SCAN cycles without a match before stall_err sets
- TO_WIDTH, 10, stall counter width; must satisfy TIMEOUT <= 2^TO_WIDTH-1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- q_match  in  NUM_QUEUES  per-queue flag: head matches x_check/y_check and the queue is non-empty
- q_colour  in  NUM_QUEUES*RGB_SIZE  head colour of each queue; queue i occupies bits [i*RGB_SIZE +: RGB_SIZE]
- q_pop  out  NUM_QUEUES  one-hot pop strobe; the queue advances its head at the clock edge where its bit is high
- x_check  out  DATA_WIDTH  expected x coordinate, registered
- y_check  out  DATA_WIDTH  expected y coordinate, registered
- out_data  out  RGB_SIZE  pixel colour
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the pixel
- out_sof  out  1  qualifies out_data as pixel (0,0)
- out_eol  out  1  qualifies out_data as the last pixel of a line
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- busy  out  1  high whenever the state is not IDLE
- stall_err  out  1  sticky: SCAN timeout occurred
- dup_err  out  1  sticky: more than one q_match bit was high on a load cycle

Behaviour:
- Reset values: state IDLE; x_check=0; y_check=0; q_pop=0; out_valid=0; out_data=0; out_sof=0; out_eol=0; frame_done=0; busy=0; stall_err=0; dup_err=0; stall counter=0.
- Reset asserted mid-frame aborts the frame immediately. Queue contents are not this block's responsibility.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - x_check=0, y_check=0; q_pop=0.
  - start=1 -> SCAN next cycle. Both sticky errors clear on start.
- SCAN:
  - load_ok = !out_valid || out_ready.
  - hit = |q_match.
  - q_pop is combinational: one-hot of the lowest-index set bit of q_match, gated by (state==SCAN && load_ok). It is never asserted in any other state.
- Load cycle (SCAN && load_ok && hit):
  - out_data <= colour of the selected queue; out_valid <= 1.
  - out_sof <= (x_check==0 && y_check==0); out_eol <= (x_check==H_RES-1).
  - If x_check==H_RES-1: x_check <= 0 and y_check <= y_check+1; otherwise x_check <= x_check+1.
  - If x_check==H_RES-1 && y_check==V_RES-1: counters return to 0 and the state goes to DRAIN.
  - If popcount(q_match)>1, dup_err <= 1. The lowest index still wins.
- Throughput and latency:
  - One pixel per clock when out_ready is held high.
  - Latency from q_match to out_valid is 1 cycle.
- Output hold cycle (out_valid && !out_ready):
  - out_data, out_sof, out_eol, out_valid, x_check and y_check all hold.
  - q_pop=0.
- Consume without load (SCAN && out_ready && out_valid && !hit): out_valid <= 0 next cycle.
- Stall counter:
  - Increments on SCAN cycles where load_ok && !hit, saturating at TIMEOUT.
  - Clears on every load.
  - On reaching TIMEOUT, stall_err <= 1 (sticky). The FSM keeps scanning and does not abort.
- DRAIN: waits for out_valid && out_ready on the final pixel, then goes to DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- x_check and y_check change only on load cycles, so the queues see a stable compare value throughout any stall.

Test Plan:
- Ordered single queue (H_RES=4, V_RES=2; queue 0 supplies (0,0)..(3,1) with colours 0x000001..0x000008; out_ready=1) -> 8 beats, colours 1..8 in order; out_sof only on beat 1; out_eol on beats 4 and 8; frame_done one cycle after the beat-8 accept; busy returns low.
- Interleaved engines: queue 0 holds even x, queue 1 holds odd x -> q_pop alternates 0001, 0010; output stays in raster order with no gap cycles.
- Backpressure: out_ready=0 for 5 cycles at pixel (2,0) -> out_data and x_check=2 hold; q_pop=0 throughout; the stream resumes with no loss or duplication.
- Simultaneous match: q_match=0110 on a load cycle -> q_pop=0010, dup_err=1 and remains set until the next start.
- Starvation: TIMEOUT=15, no q_match for 20 cycles in SCAN -> stall_err rises after the 15th idle cycle; a later match still loads correctly.
- Reset mid-frame at pixel (1,1): out_valid=0, x_check=y_check=0, state IDLE; a start after the reset runs a full frame correctly.

Source files
------------

// File: rtl/pixel_reorder_arbiter.sv
// Reorders per-engine pixel queues into a raster-order valid/ready stream.
// Broadcasts the next expected coordinate and pops the lowest matching head.
module pixel_reorder_arbiter #(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 10,
  parameter int RGB_SIZE   = 24,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int TIMEOUT    = 1023,
  parameter int TO_WIDTH   = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_QUEUES-1:0]          q_match,
  input  logic [NUM_QUEUES*RGB_SIZE-1:0] q_colour,
  output logic [NUM_QUEUES-1:0]          q_pop,
  output logic [DATA_WIDTH-1:0]          x_check,
  output logic [DATA_WIDTH-1:0]          y_check,
  output logic [RGB_SIZE-1:0]            out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sof,
  output logic                           out_eol,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           stall_err,
  output logic                           dup_err
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(H_RES - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(V_RES - 1);
  localparam logic [TO_WIDTH-1:0]   TO_MAX = TO_WIDTH'(TIMEOUT);

  state_t state, state_nxt;

  logic                  load_ok;
  logic                  hit;
  logic                  load;
  logic                  last_px;
  logic                  multi;
  logic [NUM_QUEUES-1:0] sel;
  logic [RGB_SIZE-1:0]   sel_colour;
  logic [TO_WIDTH-1:0]   stall_cnt;
  logic [TO_WIDTH-1:0]   stall_nxt;

  assign load_ok = !out_valid || out_ready;
  assign hit     = |q_match;
  assign sel     = q_match & (~q_match + NUM_QUEUES'(1));
  assign multi   = |(q_match & (q_match - NUM_QUEUES'(1)));
  assign load    = (state == SCAN) && load_ok && hit;
  assign last_px = (x_check == X_LAST) && (y_check == Y_LAST);
  assign q_pop   = (state == SCAN && load_ok) ? sel : '0;

  assign stall_nxt = (stall_cnt == TO_MAX) ? stall_cnt
                   : stall_cnt + TO_WIDTH'(1);

  always_comb begin
    sel_colour = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (sel[i]) sel_colour = q_colour[i*RGB_SIZE +: RGB_SIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SCAN;
      end
      SCAN:  if (load && last_px) state_nxt = DRAIN;
      DRAIN: if (out_valid && out_ready) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_check   <= '0;
      y_check   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      stall_err <= 1'b0;
      dup_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          x_check <= '0;
          y_check <= '0;
          if (start) begin
            stall_err <= 1'b0;
            dup_err   <= 1'b0;
            stall_cnt <= '0;
          end
        end
        SCAN: begin
          if (load) begin
            out_data  <= sel_colour;
            out_valid <= 1'b1;
            out_sof   <= (x_check == '0) && (y_check == '0);
            out_eol   <= (x_check == X_LAST);
            stall_cnt <= '0;
            if (multi) dup_err <= 1'b1;
            if (x_check == X_LAST) begin
              x_check <= '0;
              y_check <= last_px ? '0 : y_check + DATA_WIDTH'(1);
            end else begin
              x_check <= x_check + DATA_WIDTH'(1);
            end
          end else if (load_ok) begin
            // Previous beat consumed (or none pending) and nothing to load
            out_valid <= 1'b0;
            stall_cnt <= stall_nxt;
            if (stall_nxt == TO_MAX) stall_err <= 1'b1;
          end
        end
        DRAIN: if (out_valid && out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_reorder_arbiter.sv
// Scoreboard bench for pixel_reorder_arbiter on a 4x2 frame.
// Engine queues are modelled in the bench and compared in raster order.
module tb_pixel_reorder_arbiter;

  localparam int NQ = 4;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] col;
  } ent_t;

  typedef struct packed {
    logic [23:0] col;
    logic        sof;
    logic        eol;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NQ-1:0] q_match = '0;
  logic [95:0]   q_colour = '0;
  logic [NQ-1:0] q_pop;
  logic [9:0]    x_check;
  logic [9:0]    y_check;
  logic [23:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sof;
  logic          out_eol;
  logic          frame_done;
  logic          busy;
  logic          stall_err;
  logic          dup_err;

  pixel_reorder_arbiter #(
    .NUM_QUEUES(NQ),
    .DATA_WIDTH(10),
    .RGB_SIZE  (24),
    .H_RES     (4),
    .V_RES     (2),
    .TIMEOUT   (15),
    .TO_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q_match   (q_match),
    .q_colour  (q_colour),
    .q_pop     (q_pop),
    .x_check   (x_check),
    .y_check   (y_check),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .frame_done(frame_done),
    .busy      (busy),
    .stall_err (stall_err),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  ent_t          eq[NQ][$];
  exp_t          exp_q[$];
  logic [NQ-1:0] pop_log[$];
  logic [NQ-1:0] pend_pop = '0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nbeats = 0;
  int   first_acc = -1;
  int   last_acc = 0;
  int   done_cyc = 0;
  int   bp_cnt = 0;
  int   bp_left = 0;
  bit   bp_req = 0;
  bit   bp_fired = 0;
  bit   starve = 0;
  bit   log_pop = 0;
  bit   dup_on = 0;
  logic [23:0] hold_col = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic upd_loop();
    logic [NQ-1:0] m;
    logic [95:0]   c;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NQ; i++)
        if (pend_pop[i] && eq[i].size() != 0) void'(eq[i].pop_front());
      if (!bp_req) bp_fired = 0;
      else if (!bp_fired && x_check == 10'd2 && y_check == 10'd0
               && out_valid) begin
        bp_fired = 1;
        bp_left  = 5;
      end
      if (bp_left > 0) begin
        out_ready = 1'b0;
        bp_left--;
      end else begin
        out_ready = 1'b1;
      end
      m = '0;
      c = '0;
      for (int i = 0; i < NQ; i++) begin
        if (!starve && eq[i].size() != 0) begin
          c[i*24 +: 24] = eq[i][0].col;
          m[i] = (eq[i][0].x == x_check) && (eq[i][0].y == y_check);
        end
      end
      q_match  = m;
      q_colour = c;
    end
  endtask

  task automatic mon_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      pend_pop = q_pop;
      if (frame_done) done_cyc = cyc;
      if (!reset && out_valid && out_ready) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        nbeats++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", out_data, e.col);
          chk("sof", out_sof, e.sof);
          chk("eol", out_eol, e.eol);
        end
      end
      if (log_pop && q_pop != '0) pop_log.push_back(q_pop);
      if (dup_on && q_match == 4'b0110 && out_ready)
        chk("dup_pop", q_pop, 4'b0010);
      if (bp_req && !out_ready && !reset) begin
        bp_cnt++;
        chk("bp_pop", q_pop, 0);
        chk("bp_x", x_check, 2);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, hold_col);
      end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NQ; i++) eq[i].delete();
    exp_q.delete();
  endtask

  task automatic build_frame(input int mode, input logic [23:0] base);
    ent_t e;
    exp_t x_e;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.col = base + 24'(y * 4 + x + 1);
        x_e.col = e.col;
        x_e.sof = (x == 0 && y == 0);
        x_e.eol = (x == 3);
        exp_q.push_back(x_e);
        if (mode == 1) begin
          eq[x % 2].push_back(e);
        end else if (mode == 2 && x == 2 && y == 0) begin
          eq[1].push_back(e);
          e.col = 24'hBAD000;
          eq[2].push_back(e);
        end else begin
          eq[0].push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_start();
    nbeats    = 0;
    first_acc = -1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!frame_done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    @(negedge clk);
    chk("done_pulse", frame_done, 0);
    chk("busy_idle", busy, 0);
    chk("exp_empty", exp_q.size(), 0);
    chk("beats", nbeats, 8);
  endtask

  initial begin
    fork
      upd_loop();
      mon_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_x", x_check, 0);
    chk("rst_y", y_check, 0);
    chk("rst_pop", q_pop, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_err, 0);
    chk("rst_dup", dup_err, 0);

    // ordered single queue
    build_frame(0, 24'h0);
    pulse_start();
    chk("busy_run", busy, 1);
    wait_done(50);
    chk("done_lat", done_cyc - last_acc, 1);
    chk("t1_span", last_acc - first_acc, 7);

    // interleaved engines
    clear_all();
    build_frame(1, 24'h000100);
    pop_log.delete();
    log_pop = 1;
    pulse_start();
    wait_done(50);
    log_pop = 0;
    chk("t2_span", last_acc - first_acc, 7);
    chk("t2_npop", pop_log.size(), 8);
    for (int k = 0; k < pop_log.size(); k++)
      chk("t2_pop", pop_log[k], (k % 2 == 1) ? 2 : 1);

    // backpressure while x_check holds 2
    clear_all();
    build_frame(0, 24'h100000);
    hold_col = 24'h100002;
    bp_cnt = 0;
    bp_req = 1;
    pulse_start();
    wait_done(60);
    bp_req = 0;
    chk("bp_cycles", bp_cnt, 5);

    // simultaneous match
    clear_all();
    chk("dup_before", dup_err, 0);
    build_frame(2, 24'h200000);
    dup_on = 1;
    pulse_start();
    wait_done(50);
    dup_on = 0;
    chk("dup_set", dup_err, 1);
    repeat (3) @(negedge clk);
    chk("dup_sticky", dup_err, 1);

    // starvation
    clear_all();
    starve = 1;
    build_frame(0, 24'h300000);
    pulse_start();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) chk("dup_clear", dup_err, 0);
      chk("stall", stall_err, (i >= 16) ? 1 : 0);
      chk("stall_nov", out_valid, 0);
    end
    starve = 0;
    wait_done(50);
    chk("stall_sticky", stall_err, 1);

    // reset mid-frame at (1,1)
    clear_all();
    build_frame(0, 24'h400000);
    pulse_start();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (x_check == 10'd1 && y_check == 10'd1) break;
    end
    chk("mid_reached", {x_check == 10'd1, y_check == 10'd1}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_x", x_check, 0);
    chk("mrst_y", y_check, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_pop", q_pop, 0);
    reset = 1'b0;
    clear_all();
    build_frame(0, 24'h500000);
    pulse_start();
    wait_done(50);
    chk("t6_span", last_acc - first_acc, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
